booth_arbiter: RTL and testbench

Round-robin arbiter that shares a single voting booth among `N_REQ` requesters and screens each requester's age before admitting it. An eligible requester (age > `VOTE_MIN`) receives an exclusive grant for `BOOTH_CYCLES` cycles; an ineligible one receives a one-cycle reject. The block also keeps saturating vote and reject counts. It sits in front of the shared booth/eligibility datapath and is the only block that sequences access to it.

---
 rtl/booth_arbiter.sv | 174 +++++++++++++++++
 tb/tb_booth_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_arbiter.sv
// Round-robin arbiter sharing one voting booth; screens age before granting a timed session.
// Optional feature macro BOOTH_CANDIDATE_EN adds the candidate flag (granted age > CAND_MIN).
module booth_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned AGE_W        = 7,
    parameter int unsigned VOTE_MIN     = 18,
    parameter int unsigned CAND_MIN     = 30,
    parameter int unsigned BOOTH_CYCLES = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*AGE_W-1:0] age,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic [N_REQ-1:0]       reject,
    output logic                   candidate,
    output logic                   busy,
    output logic [CNT_W-1:0]       vote_cnt,
    output logic [CNT_W-1:0]       reject_cnt
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TmrW = (BOOTH_CYCLES > 1) ? $clog2(BOOTH_CYCLES) : 1;
    localparam logic [TmrW-1:0]  TmrLoad = TmrW'(BOOTH_CYCLES - 1);
    localparam logic [N_REQ-1:0] OneHot0 = N_REQ'(1);
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {StIdle, StCheck, StBooth, StRelease} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic [N_REQ-1:0]  reject_q, reject_d;
    logic              cand_q, cand_d;
    logic [CNT_W-1:0]  vote_q, vote_d;
    logic [CNT_W-1:0]  rej_q, rej_d;

    logic              pick_valid;
    logic [IdxW-1:0]   pick_idx;
    logic [IdxW-1:0]   scan;
    logic              req_sel;
    logic [AGE_W-1:0]  age_sel;
    logic              eligible;
    logic              cand_hit;

    // First asserted request at or above the pointer, wrapping around.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan = IdxW'((32'(ptr_q) + i) % N_REQ);
            if (!pick_valid && req[scan]) begin
                pick_valid = 1'b1;
                pick_idx   = scan;
            end
        end
    end

    always_comb begin
        req_sel = 1'b0;
        age_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (idx_q == IdxW'(i)) begin
                req_sel = req[i];
                age_sel = age[i*AGE_W +: AGE_W];
            end
        end
    end

    assign eligible = 32'(age_sel) > VOTE_MIN;

`ifdef BOOTH_CANDIDATE_EN
    assign cand_hit = 32'(age_sel) > CAND_MIN;
`else
    assign cand_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        tmr_d    = tmr_q;
        grant_d  = grant_q;
        done_d   = '0;
        reject_d = '0;
        cand_d   = cand_q;
        vote_d   = vote_q;
        rej_d    = rej_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    idx_d   = pick_idx;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (!req_sel) begin
                    state_d = StRelease;
                end else if (eligible) begin
                    state_d = StBooth;
                    tmr_d   = TmrLoad;
                    grant_d = OneHot0 << idx_q;
                    cand_d  = cand_hit;
                end else begin
                    state_d  = StRelease;
                    reject_d = OneHot0 << idx_q;
                    if (rej_q != CntMax) rej_d = rej_q + 1'b1;
                end
            end
            StBooth: begin
                if (!req_sel) begin
                    state_d = StRelease;
                    grant_d = '0;
                    cand_d  = 1'b0;
                end else if (tmr_q == '0) begin
                    state_d = StRelease;
                    done_d  = grant_q;
                    grant_d = '0;
                    cand_d  = 1'b0;
                    if (vote_q != CntMax) vote_d = vote_q + 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StRelease: begin
                // Pointer advances past the served index whatever the outcome.
                state_d = StIdle;
                ptr_d   = (idx_q == IdxW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            ptr_q    <= '0;
            tmr_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            reject_q <= '0;
            cand_q   <= 1'b0;
            vote_q   <= '0;
            rej_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            tmr_q    <= tmr_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            reject_q <= reject_d;
            cand_q   <= cand_d;
            vote_q   <= vote_d;
            rej_q    <= rej_d;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign reject     = reject_q;
    assign candidate  = cand_q;
    assign busy       = (state_q != StIdle);
    assign vote_cnt   = vote_q;
    assign reject_cnt = rej_q;

endmodule

// File: tb/tb_booth_arbiter.sv
// Bench for booth_arbiter: timestamp-based session model checked every cycle, plus directed
// vectors with literal expectations (counters use a narrow width so saturation is reachable).
module tb_booth_arbiter;

    localparam int N    = 4;
    localparam int AW   = 7;
    localparam int VMIN = 18;
    localparam int CMIN = 30;
    localparam int B    = 4;
    localparam int CW   = 3;
`ifdef BOOTH_CANDIDATE_EN
    localparam int CAND_ON = 1;
`else
    localparam int CAND_ON = 0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] age;
    logic [N-1:0]    grant, done, reject;
    logic            candidate, busy;
    logic [CW-1:0]   vote_cnt, reject_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    booth_arbiter #(
        .N_REQ(N), .AGE_W(AW), .VOTE_MIN(VMIN), .CAND_MIN(CMIN),
        .BOOTH_CYCLES(B), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .age(age),
        .grant(grant), .done(done), .reject(reject), .candidate(candidate),
        .busy(busy), .vote_cnt(vote_cnt), .reject_cnt(reject_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a session starts at the pick edge t0; every later event is a fixed offset from t0.
    int           cyc = 0;
    bit           m_busy = 1'b0;
    int           m_idx = 0, m_ptr = 0, m_t0 = 0, m_rel = 1 << 30;
    logic [N-1:0] m_grant = '0, m_done = '0, m_rej = '0;
    logic         m_cand = 1'b0;
    int           m_vote = 0, m_rcnt = 0;
    localparam int CMAX = (1 << CW) - 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_ptr = 0; m_idx = 0; m_rel = 1 << 30;
            m_grant = '0; m_done = '0; m_rej = '0; m_cand = 1'b0;
            m_vote = 0; m_rcnt = 0;
        end else begin
            cyc++;
            m_done = '0;
            m_rej  = '0;
            if (m_busy && cyc == m_rel + 1) begin
                m_busy = 1'b0;
                m_ptr  = (m_idx + 1) % N;
            end else if (!m_busy) begin
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = (m_ptr + i) % N;
                    if (!m_busy && bit'(req >> k)) begin
                        m_busy = 1'b1; m_idx = k; m_t0 = cyc; m_rel = 1 << 30;
                    end
                end
            end else if (cyc == m_t0 + 1) begin
                if (!bit'(req >> m_idx)) begin
                    m_rel = cyc;
                end else if (int'(AW'(age >> (m_idx * AW))) > VMIN) begin
                    m_grant = N'(1) << m_idx;
                    m_cand  = (CAND_ON != 0) && (int'(AW'(age >> (m_idx * AW))) > CMIN);
                end else begin
                    m_rej = N'(1) << m_idx;
                    if (m_rcnt < CMAX) m_rcnt++;
                    m_rel = cyc;
                end
            end else if (m_grant != '0) begin
                if (!bit'(req >> m_idx)) begin
                    m_grant = '0; m_cand = 1'b0; m_rel = cyc;
                end else if (cyc == m_t0 + B + 1) begin
                    m_done = m_grant; m_grant = '0; m_cand = 1'b0; m_rel = cyc;
                    if (m_vote < CMAX) m_vote++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("grant", 32'(grant), 32'(m_grant));
            chk("done", 32'(done), 32'(m_done));
            chk("reject", 32'(reject), 32'(m_rej));
            chk("candidate", 32'(candidate), 32'(m_cand));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("vote_cnt", 32'(vote_cnt), 32'(m_vote));
            chk("reject_cnt", 32'(reject_cnt), 32'(m_rcnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_age(input int i, input int v);
        age[i*AW +: AW] = AW'(v);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 10; t++) begin
            if (!busy) break;
            tick();
        end
        chk("return_idle", 32'(busy), 32'(0));
    endtask

    // Raise a request, observe the session until done/reject, then withdraw in RELEASE.
    task automatic run(input logic [N-1:0] r, output int gcyc, output logic [N-1:0] gv,
                       output logic [N-1:0] dv, output logic [N-1:0] rv, output bit cs);
        req = r; gcyc = 0; gv = '0; dv = '0; rv = '0; cs = 1'b0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (grant != '0) begin
                gcyc++; gv = grant;
                if (candidate) cs = 1'b1;
            end
            if (done != '0 || reject != '0) begin
                dv = done; rv = reject;
                break;
            end
        end
        req = '0;
        wait_idle();
    endtask

    int           gc;
    logic [N-1:0] gv, dv, rv, prev;
    bit           cs;
    int           order[$];
    int           rr_exp[5] = '{0, 1, 2, 3, 0};

    initial begin
        req = '0; age = '0; rst = 1'b1;
        repeat (3) tick();
        chk_en = 1'b1;
        tick();
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_vote", 32'(vote_cnt), 32'(0));
        rst = 1'b0;
        tick();

        set_age(0, 25);
        run(4'b0001, gc, gv, dv, rv, cs);
        chk("single_gcyc", 32'(gc), 32'(4));
        chk("single_grant", 32'(gv), 32'h1);
        chk("single_done", 32'(dv), 32'h1);
        chk("single_vote", 32'(vote_cnt), 32'(1));

        set_age(0, 18);
        run(4'b0001, gc, gv, dv, rv, cs);
        chk("age18_gcyc", 32'(gc), 32'(0));
        chk("age18_reject", 32'(rv), 32'h1);
        chk("age18_rcnt", 32'(reject_cnt), 32'(1));

        set_age(0, 19);
        run(4'b0001, gc, gv, dv, rv, cs);
        chk("age19_grant", 32'(gv), 32'h1);
        chk("age19_done", 32'(dv), 32'h1);
        chk("age19_vote", 32'(vote_cnt), 32'(2));

        // Asynchronous reset in the middle of a session for requester 2.
        set_age(2, 40);
        req = 4'b0100;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (grant == 4'b0100) break;
        end
        tick();
        chk("pre_rst_grant", 32'(grant), 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_vote", 32'(vote_cnt), 32'(0));
        chk("arst_rcnt", 32'(reject_cnt), 32'(0));
        req = '0;
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < N; i++) set_age(i, 40);
        req = 4'b1111; prev = '0;
        for (int t = 0; t < 200 && order.size() < 5; t++) begin
            tick();
            if (grant != '0 && prev == '0) begin
                for (int i = 0; i < N; i++) if (grant == (N'(1) << i)) order.push_back(i);
            end
            prev = grant;
        end
        req = '0;
        wait_idle();
        chk("rr_count", 32'(order.size()), 32'(5));
        for (int i = 0; i < 5 && i < order.size(); i++) chk("rr_order", 32'(order[i]), 32'(rr_exp[i]));
        chk("rr_vote", 32'(vote_cnt), 32'(4));

        set_age(1, 20);
        req = 4'b0010; gc = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (grant == 4'b0010) gc++;
            if (gc == 2) break;
        end
        chk("abort_granted", 32'(gc), 32'(2));
        req = '0;
        tick();
        chk("abort_grant", 32'(grant), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        wait_idle();
        chk("abort_vote", 32'(vote_cnt), 32'(4));

        set_age(0, 40); set_age(2, 40);
        run(4'b0101, gc, gv, dv, rv, cs);
        chk("ptr_after_abort", 32'(gv), 32'h4);
        chk("ptr_done", 32'(dv), 32'h4);

        set_age(2, 31);
        run(4'b0100, gc, gv, dv, rv, cs);
        chk("cand31", 32'(cs), 32'(CAND_ON));
        set_age(2, 30);
        run(4'b0100, gc, gv, dv, rv, cs);
        chk("cand30", 32'(cs), 32'(0));
        chk("vote_full", 32'(vote_cnt), 32'(7));
        set_age(2, 50);
        run(4'b0100, gc, gv, dv, rv, cs);
        chk("vote_sat", 32'(vote_cnt), 32'(7));

        set_age(0, 5);
        repeat (8) run(4'b0001, gc, gv, dv, rv, cs);
        chk("rcnt_sat", 32'(reject_cnt), 32'(7));

        tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
